// File: rtl/xor_accum_pkg.sv
// Shared encodings for the xor_accum_unit slice: bitwise op selects and
// control FSM states.
package xor_accum_pkg;

  typedef enum logic [1:0] {
    OP_XOR  = 2'b00,
    OP_XNOR = 2'b01,
    OP_AND  = 2'b10,
    OP_OR   = 2'b11
  } op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_ACC  = 1'b1
  } state_e;

endpackage

// File: rtl/bitwise_op.sv
// Combinational datapath leaf: r = a op b, applied independently per bit
// (no carries), with op chosen from the package encodings.
module bitwise_op
  import xor_accum_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] r
);

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign r[gi] = (op == OP_AND)  ? (a[gi] & b[gi])    :
                     (op == OP_OR)   ? (a[gi] | b[gi])    :
                     (op == OP_XNOR) ? ~(a[gi] ^ b[gi])   :
                                       (a[gi] ^ b[gi]);
    end
  endgenerate

endmodule

// File: rtl/xor_accum_unit.sv
// Registered bitwise-op unit: emits a per-beat result in pass mode, or folds
// beats of a frame by XOR into a checksum emitted once when the frame closes.
module xor_accum_unit
  import xor_accum_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  input  logic             acc_en,
  input  logic             last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             y_parity,
  output logic [CNT_W-1:0] out_beats
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             par_q, par_d;
  logic [CNT_W-1:0] beats_q, beats_d;
  logic             out_valid_q, out_valid_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] fold;
  logic [CNT_W-1:0] cnt_inc;
  logic             accept;
  logic             take;
  logic             emit;
  logic [WIDTH-1:0] emit_val;
  logic [CNT_W-1:0] emit_beats;

  bitwise_op #(.WIDTH(WIDTH)) u_op (
    .a  (a),
    .b  (b),
    .op (op),
    .r  (r)
  );

  assign in_ready  = !out_valid_q || out_ready;
  assign accept    = in_valid && in_ready;
  assign take      = out_valid_q && out_ready;
  assign fold      = acc_q ^ r;
  assign cnt_inc   = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_ONE;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    y_d         = y_q;
    par_d       = par_q;
    beats_d     = beats_q;
    out_valid_d = out_valid_q;
    err_d       = err_q;
    emit        = 1'b0;
    emit_val    = '0;
    emit_beats  = '0;

    if (take) begin
      out_valid_d = 1'b0;
    end

    if (accept) begin
      case (state_q)
        S_IDLE: begin
          if (!acc_en || last) begin
            emit       = 1'b1;
            emit_val   = r;
            emit_beats = CNT_ONE;
          end else begin
            acc_d   = r;
            cnt_d   = CNT_ONE;
            state_d = S_ACC;
          end
        end
        S_ACC: begin
          if (acc_en && !last) begin
            acc_d = fold;
            cnt_d = cnt_inc;
          end else begin
            // A pass beat arriving mid-frame closes the frame as if it were last.
            emit       = 1'b1;
            emit_val   = fold;
            emit_beats = cnt_inc;
            acc_d      = '0;
            cnt_d      = '0;
            state_d    = S_IDLE;
            if (!acc_en) begin
              err_d = 1'b1;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (emit) begin
      y_d         = emit_val;
      par_d       = ^emit_val;
      beats_d     = emit_beats;
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      y_q         <= '0;
      par_q       <= 1'b0;
      beats_q     <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      y_q         <= y_d;
      par_q       <= par_d;
      beats_q     <= beats_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign y_parity  = par_q;
  assign out_beats = beats_q;

endmodule

// File: tb/tb_xor_accum_unit.sv
// Self-checking bench for xor_accum_unit: directed table/sequences plus a
// randomized frame-level scoreboard run.
module tb_xor_accum_unit;
  import xor_accum_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic [1:0]  op = '0;
  logic        acc_en = 1'b0;
  logic        last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] y;
  logic        y_parity;
  logic [7:0]  out_beats;

  logic        s_in_ready;
  logic        s_out_valid;
  logic [15:0] s_y;
  logic        s_y_parity;
  logic [1:0]  s_out_beats;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  xor_accum_unit #(.WIDTH(16), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .acc_en(acc_en), .last(last),
    .out_valid(out_valid), .out_ready(out_ready), .y(y),
    .y_parity(y_parity), .out_beats(out_beats)
  );

  xor_accum_unit #(.WIDTH(16), .CNT_W(2)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
    .a(a), .b(b), .op(op), .acc_en(acc_en), .last(last),
    .out_valid(s_out_valid), .out_ready(out_ready), .y(s_y),
    .y_parity(s_y_parity), .out_beats(s_out_beats)
  );

  typedef struct {
    logic [15:0] va;
    logic [15:0] vb;
    logic [1:0]  vop;
    logic [15:0] exp_y;
    logic        exp_par;
  } vec_t;

  typedef struct {
    logic [15:0] va;
    logic [15:0] vb;
    logic [1:0]  vop;
    logic        ven;
    logic        vlast;
  } beat_t;

  typedef struct {
    logic [15:0] ey;
    int          en;
  } exp_t;

  function automatic logic [15:0] model_op(input logic [15:0] x, input logic [15:0] z,
                                           input logic [1:0] o);
    case (o)
      2'd0:    return x ^ z;
      2'd1:    return ~(x ^ z);
      2'd2:    return x & z;
      default: return x | z;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Presents one beat for one cycle; the caller keeps out_ready so in_ready holds.
  task automatic send(input logic [15:0] ta, input logic [15:0] tb_, input logic [1:0] top,
                      input logic ten, input logic tlast);
    a = ta; b = tb_; op = top; acc_en = ten; last = tlast; in_valid = 1'b1;
    #1;
    chk("send_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  vec_t  vecs[4];
  beat_t beats[$];
  exp_t  expq[$];

  initial begin
    vecs[0] = '{16'hF0F0, 16'h0FF0, 2'b00, 16'hFF00, 1'b0};
    vecs[1] = '{16'hF0F0, 16'h0FF0, 2'b01, 16'h00FF, 1'b0};
    vecs[2] = '{16'hF0F0, 16'h0FF0, 2'b10, 16'h00F0, 1'b0};
    vecs[3] = '{16'hF0F0, 16'h0FF0, 2'b11, 16'hFFF0, 1'b0};

    // Reset state
    do_reset();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_y", 32'(y), 32'd0);
    chk("rst_parity", 32'(y_parity), 32'd0);
    chk("rst_beats", 32'(out_beats), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_err", 32'(dut.err_q), 32'd0);

    // Pass-mode op sweep
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(vecs[i].va, vecs[i].vb, vecs[i].vop, 1'b0, 1'b0);
      chk($sformatf("pass%0d_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("pass%0d_y", i), 32'(y), 32'(vecs[i].exp_y));
      chk($sformatf("pass%0d_beats", i), 32'(out_beats), 32'd1);
      chk($sformatf("pass%0d_par", i), 32'(y_parity), 32'(vecs[i].exp_par));
    end

    // Three-beat XOR frame
    send(16'h0001, 16'h0000, 2'b00, 1'b1, 1'b0);
    chk("frm_b1_valid", 32'(out_valid), 32'd0);
    send(16'h0002, 16'h0000, 2'b00, 1'b1, 1'b0);
    chk("frm_b2_valid", 32'(out_valid), 32'd0);
    send(16'h0004, 16'h0000, 2'b00, 1'b1, 1'b1);
    chk("frm_valid", 32'(out_valid), 32'd1);
    chk("frm_y", 32'(y), 32'h0007);
    chk("frm_beats", 32'(out_beats), 32'd3);
    chk("frm_par", 32'(y_parity), 32'd1);

    // Backpressure: hold a result, then stream back-to-back
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    send(16'hAAAA, 16'h0000, 2'b00, 1'b0, 1'b0);
    chk("bp_first_y", 32'(y), 32'hAAAA);
    a = 16'h1111; b = 16'h0000; op = 2'b00; acc_en = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("bp_hold%0d_in_ready", i), 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      chk($sformatf("bp_hold%0d_y", i), 32'(y), 32'hAAAA);
      chk($sformatf("bp_hold%0d_valid", i), 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a = 16'h1111 * 16'(i + 1);
      #1;
      @(posedge clk);
      #1;
      chk($sformatf("b2b%0d_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("b2b%0d_y", i), 32'(y), 32'(16'h1111 * 16'(i + 1)));
    end
    in_valid = 1'b0;

    // Saturation on the CNT_W=2 instance; the wide instance counts all six
    do_reset();
    for (int i = 0; i < 6; i++) begin
      send(16'h0001, 16'h0000, 2'b00, 1'b1, (i == 5) ? 1'b1 : 1'b0);
    end
    chk("sat_valid", 32'(s_out_valid), 32'd1);
    chk("sat_y", 32'(s_y), 32'h0000);
    chk("sat_beats", 32'(s_out_beats), 32'd3);
    chk("sat_wide_beats", 32'(out_beats), 32'd6);

    // Reset mid-frame discards the accumulator
    @(posedge clk);
    #1;
    send(16'h0F0F, 16'h0000, 2'b00, 1'b1, 1'b0);
    send(16'h5000, 16'h0000, 2'b00, 1'b1, 1'b0);
    do_reset();
    chk("rmf_state", 32'(dut.state_q), 32'(S_IDLE));
    send(16'h1234, 16'h0000, 2'b00, 1'b0, 1'b0);
    chk("rmf_y", 32'(y), 32'h1234);
    chk("rmf_beats", 32'(out_beats), 32'd1);

    // Protocol violation closes the frame and sets the sticky flag
    send(16'h0003, 16'h0000, 2'b00, 1'b1, 1'b0);
    send(16'h0004, 16'h0000, 2'b00, 1'b0, 1'b0);
    chk("vio_y", 32'(y), 32'h0007);
    chk("vio_beats", 32'(out_beats), 32'd2);
    chk("vio_state", 32'(dut.state_q), 32'(S_IDLE));
    chk("vio_err", 32'(dut.err_q), 32'd1);
    send(16'h0009, 16'h0000, 2'b00, 1'b0, 1'b0);
    chk("vio_err_sticky", 32'(dut.err_q), 32'd1);
    chk("vio_pass_y", 32'(y), 32'h0009);
    do_reset();
    chk("vio_err_cleared", 32'(dut.err_q), 32'd0);

    // Randomized frames against a frame-level model
    for (int f = 0; f < 40; f++) begin
      int kind;
      int n;
      logic [15:0] accv;
      beat_t bt;
      exp_t  ex;
      kind = $urandom_range(0, 2);
      if (kind == 0) begin
        bt.va = 16'($urandom); bt.vb = 16'($urandom); bt.vop = 2'($urandom);
        bt.ven = 1'b0; bt.vlast = 1'($urandom);
        beats.push_back(bt);
        ex.ey = model_op(bt.va, bt.vb, bt.vop);
        ex.en = 1;
        expq.push_back(ex);
      end else begin
        n = $urandom_range(1, 7);
        accv = '0;
        for (int k = 0; k < n; k++) begin
          bt.va = 16'($urandom); bt.vb = 16'($urandom); bt.vop = 2'($urandom);
          bt.ven = 1'b1; bt.vlast = (k == n - 1);
          beats.push_back(bt);
          accv = accv ^ model_op(bt.va, bt.vb, bt.vop);
        end
        ex.ey = accv;
        ex.en = n;
        expq.push_back(ex);
      end
    end

    begin
      int idx = 0;
      int cyc = 0;
      int got = 0;
      int nexp = expq.size();
      logic        held = 1'b0;
      logic [15:0] held_y = '0;
      while ((got < nexp) && (cyc < 5000)) begin
        bit do_in;
        do_in = (idx < beats.size()) && ($urandom_range(0, 3) != 0);
        in_valid = do_in;
        if (idx < beats.size()) begin
          a = beats[idx].va; b = beats[idx].vb; op = beats[idx].vop;
          acc_en = beats[idx].ven; last = beats[idx].vlast;
        end
        out_ready = ($urandom_range(0, 3) != 0);
        #1;
        if (held) begin
          chk($sformatf("rnd_stable_c%0d", cyc), 32'(y), 32'(held_y));
        end
        if (out_valid && out_ready) begin
          if (expq.size() == 0) begin
            chk("rnd_unexpected_output", 32'(out_valid), 32'd0);
          end else begin
            exp_t e;
            int   eb;
            e = expq.pop_front();
            eb = (e.en > 255) ? 255 : e.en;
            chk($sformatf("rnd%0d_y", got), 32'(y), 32'(e.ey));
            chk($sformatf("rnd%0d_beats", got), 32'(out_beats), 32'(eb));
            chk($sformatf("rnd%0d_par", got), 32'(y_parity), 32'(^e.ey));
            got++;
          end
        end
        held = out_valid && !out_ready;
        held_y = y;
        if (do_in && in_ready) idx++;
        @(posedge clk);
        #1;
        cyc++;
      end
      in_valid = 1'b0;
      if (got < nexp) begin
        chk("rnd_timeout_outputs", 32'(got), 32'(nexp));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
